// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multi-cycle MIPS controller
// Purpose: opcode constants, controller state encodings and datapath mux encodings.
// Ports: none (package mips_ctrl_pkg).
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath signal bundle
// Purpose: groups opcode, memory handshake and all datapath controls.
// Modports: master = controller (drives controls), slave = datapath/memory side.
interface multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, mem_timeout, state
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// rtl/multicycle_control_mem_wait_timer.sv - memory wait watchdog counter
// Purpose: counts consecutive not-ready cycles of a memory access and flags the limit.
// Ports: clk, reset (sync, active-high); active = in a memory state; ready = access
//        completes; restart = state is changing; expired = abort this cycle.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    input  logic restart,
    output logic expired
);
    localparam logic [15:0] LIMIT   = 16'(WAIT_LIMIT);
    localparam bit          ENABLED = (WAIT_LIMIT != 0);

    logic [15:0] wait_cnt;

    // Ready on the limit cycle wins: expiry requires ready low.
    assign expired = ENABLED && active && !ready && (wait_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || !active || ready || restart || expired) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS controller FSM
// Purpose: sequences shared ALU, memory port and write enables for R-type/lw/sw/beq/j.
// Ports: clk, reset (sync, active-high); bus (master) carries op, mem_ready,
//        datapath controls, instr_done/illegal_op pulses, mem_timeout and debug state.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t state_q, state_d;
    logic   mem_timeout_q;
    logic   in_mem_state;
    logic   expired;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (in_mem_state),
        .ready   (bus.mem_ready),
        .restart (state_d != state_q),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (expired) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = !expired;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = !expired;
                iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = !expired;
                iord       = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Watchdog abort overrides any held memory state.
        if (expired) state_d = S_FETCH;
    end

    // Reset forces every control low in the reset cycle; state stays visible.
    assign bus.pc_write      = pc_write      & ~reset;
    assign bus.pc_write_cond = pc_write_cond & ~reset;
    assign bus.iord          = iord          & ~reset;
    assign bus.mem_read      = mem_read      & ~reset;
    assign bus.mem_write     = mem_write     & ~reset;
    assign bus.ir_write      = ir_write      & ~reset;
    assign bus.mem_to_reg    = mem_to_reg    & ~reset;
    assign bus.reg_dst       = reg_dst       & ~reset;
    assign bus.reg_write     = reg_write     & ~reset;
    assign bus.alu_src_a     = alu_src_a     & ~reset;
    assign bus.alu_src_b     = alu_src_b     & {2{~reset}};
    assign bus.alu_op        = alu_op        & {2{~reset}};
    assign bus.pc_source     = pc_source     & {2{~reset}};
    assign bus.instr_done    = instr_done    & ~reset;
    assign bus.illegal_op    = illegal_op    & ~reset;
    assign bus.mem_timeout   = mem_timeout_q & ~reset;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    localparam int LIM = 4;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    logic exp_to = 1'b0;

    multicycle_control_if bus ();

    multicycle_control #(.WAIT_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [17:0] obs_ctrl;
    assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                       bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op};

    function automatic logic [17:0] mk(input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                                       input logic [1:0] asb, aop, pcs, input logic done, ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill};
    endfunction

    task automatic chk_state(input logic [3:0] e, input string tag);
        checks++;
        assert (bus.state === e) passed++;
        else $error("FAIL %s state obs=%0d exp=%0d", tag, bus.state, e);
    endtask

    task automatic chk_ctrl(input logic [17:0] e, input string tag);
        checks++;
        assert (obs_ctrl === e) passed++;
        else $error("FAIL %s ctrl obs=%b exp=%b", tag, obs_ctrl, e);
    endtask

    task automatic chk_to(input logic e, input string tag);
        checks++;
        assert (bus.mem_timeout === e) passed++;
        else $error("FAIL %s mem_timeout obs=%b exp=%b", tag, bus.mem_timeout, e);
    endtask

    // One clock: drive ready, sample mid-cycle, then advance past the edge.
    task automatic step(input logic [3:0] es, input logic [17:0] ec, input logic rdy, input string tag);
        bus.mem_ready = rdy;
        @(negedge clk);
        chk_state(es, tag);
        chk_ctrl(ec, tag);
        chk_to(exp_to, tag);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference: opcode table plus stall counts. A memory phase
    // with stall s completes on its s-th extra cycle; if s exceeds the limit the
    // access aborts on cycle LIM (0-based) back to FETCH.
    task automatic run_instr(input logic [5:0] o, input int fs, input int ms);
        logic legal;
        logic [3:0] ms_state;
        bus.op = o;
        for (int k = 0; k <= fs; k++) begin
            if (k < fs && k == LIM) begin
                step(4'd0, mk(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b0, "fetch_abort");
                exp_to = 1'b1;
                return;
            end
            if (k == fs) step(4'd0, mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b1, "fetch");
            else         step(4'd0, mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b0, "fetch_wait");
        end
        legal = (o == RTYPE) || (o == LW) || (o == SW) || (o == BEQ) || (o == JMP);
        step(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,!legal), 1'($urandom_range(0, 1)), "decode");
        if (!legal) return;
        if (o == RTYPE) begin
            step(4'd6, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0), 1'($urandom_range(0, 1)), "exec");
            step(4'd7, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0), 1'($urandom_range(0, 1)), "aluwb");
        end else if (o == BEQ) begin
            step(4'd8, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0), 1'($urandom_range(0, 1)), "branch");
        end else if (o == JMP) begin
            step(4'd9, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0), 1'($urandom_range(0, 1)), "jump");
        end else begin
            step(4'd2, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'($urandom_range(0, 1)), "memadr");
            ms_state = (o == LW) ? 4'd3 : 4'd5;
            for (int k = 0; k <= ms; k++) begin
                if (k < ms && k == LIM) begin
                    step(ms_state, mk(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0, "mem_abort");
                    exp_to = 1'b1;
                    return;
                end
                if (o == LW) step(4'd3, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), k == ms, "memrd");
                else         step(4'd5, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,k == ms,0), k == ms, "memwr");
            end
            if (o == LW)
                step(4'd4, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0), 1'($urandom_range(0, 1)), "memwb");
        end
    endtask

    initial begin
        logic [5:0] rop;
        int sel;
        reset = 1'b1;
        bus.op = RTYPE;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_state(4'd0, "reset_state");
        chk_ctrl(18'd0, "reset_ctrl");
        chk_to(1'b0, "reset_to");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(RTYPE, 0, 0);
        run_instr(LW, 0, 3);
        run_instr(BEQ, 0, 0);
        run_instr(JMP, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(SW, 0, 4);
        run_instr(SW, 1, 9);
        run_instr(LW, 2, 1);
        run_instr(SW, 0, 4);
        run_instr(RTYPE, 7, 0);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: rop = RTYPE;
                1: rop = LW;
                2: rop = SW;
                3: rop = BEQ;
                4: rop = JMP;
                default: begin
                    rop = 6'($urandom);
                    while (rop == RTYPE || rop == LW || rop == SW || rop == BEQ || rop == JMP)
                        rop = 6'($urandom);
                end
            endcase
            run_instr(rop, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
        end

        // Reset mid-store with memory ready: no write strobe, sticky flag cleared.
        if (!exp_to) run_instr(LW, 0, 8);
        bus.op = SW;
        step(4'd0, mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b1, "rst_fetch");
        step(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0), 1'b0, "rst_decode");
        step(4'd2, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'b0, "rst_memadr");
        reset = 1'b1;
        exp_to = 1'b0;
        step(4'd5, 18'd0, 1'b1, "rst_in_memwr");
        reset = 1'b0;
        run_instr(RTYPE, 0, 0);
        run_instr(SW, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS controller FSM: sequences one shared ALU, one shared memory port and IR/PC/register-file write enables across several cycles per instruction.
- Supports R-type (000000), lw (100011), sw (101011), beq (000100) and j (000010).
- Waits on memory through a ready handshake. An optional watchdog aborts memory waits that run too long.
- Sits between the IR opcode field and the multi-cycle datapath muxes and enables.

Parameters:
- WAIT_LIMIT, 0: maximum consecutive not-ready cycles in a memory state before abort. 0 disables the watchdog. Legal range 0..65535.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode from IR[31:26]; stable from DECODE until the next FETCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- mem_timeout  out  1  sticky watchdog flag
- state  out  4  current state, for debug

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, reset values and defaults:
  - On reset: state <= FETCH (0), wait_cnt <= 0, mem_timeout <= 0.
  - While reset = 1, every output except state is forced to 0.
  - Any control not listed for a state is 0.
- States, encodings, asserted outputs and transitions:
  - FETCH (0): mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write = pc_write = mem_ready. Goes to DECODE on mem_ready, otherwise holds.
  - DECODE (1): alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by op:
    - lw or sw -> MEMADR
    - R-type -> EXEC
    - beq -> BRANCH
    - j -> JUMP
    - any other op -> FETCH, with illegal_op = 1 for that cycle
  - MEMADR (2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEMRD if op = lw, otherwise MEMWR.
  - MEMRD (3): mem_read = 1, iord = 1. Goes to MEMWB on mem_ready.
  - MEMWB (4): reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. Goes to FETCH.
  - MEMWR (5): mem_write = 1, iord = 1, instr_done = mem_ready. Goes to FETCH on mem_ready.
  - EXEC (6): alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to ALUWB.
  - ALUWB (7): reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1. Goes to FETCH.
  - BRANCH (8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, instr_done = 1. Goes to FETCH.
  - JUMP (9): pc_write = 1, pc_source = 10, instr_done = 1. Goes to FETCH.
  - Encodings 10..15: all outputs 0, next state FETCH.
- Zero-wait latency in cycles:
  - R-type 4, lw 5, sw 4, beq 3, j 3.
  - Illegal opcode: 2 cycles (FETCH, DECODE), then refetch.
- Watchdog:
  - wait_cnt is 16 bits. It increments in FETCH, MEMRD or MEMWR while mem_ready = 0.
  - It clears on mem_ready = 1 or on any state change.
  - If WAIT_LIMIT != 0, wait_cnt == WAIT_LIMIT and mem_ready = 0:
    - set mem_timeout (cleared only by reset) and go to FETCH with wait_cnt = 0;
    - that cycle suppresses mem_read, mem_write, ir_write, pc_write and instr_done.
  - WAIT_LIMIT = 0: waits are unbounded.
- Simultaneous events:
  - reset beats everything.
  - mem_ready in the same cycle the limit is reached counts as success, not a timeout.
  - Reset mid-instruction (any state) returns to FETCH with no write strobe in the reset cycle.

Decomposition:
- Shared package (mips_ctrl_pkg) holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - state encodings S_FETCH..S_JUMP;
  - ALUOp, ALUSrcB and PCSource encodings.
- Sub-module mem_wait_timer (wait_cnt plus compare) is natural and reusable by other memory masters.
- The next-state logic and the output decoder stay in this module.

Test Plan:
- R-type, mem_ready tied 1:
  - state sequence is 0, 1, 6, 7, 0;
  - in state 7, reg_write = 1 and reg_dst = 1;
  - exactly one instr_done, 4 cycles after reset release.
- lw with mem_ready low for 3 cycles in MEMRD:
  - states 0, 1, 2, 3, 3, 3, 3, 4, 0;
  - mem_read = 1 and iord = 1 throughout MEMRD;
  - reg_write = 1 and mem_to_reg = 1 in state 4.
- beq then j, back to back:
  - BRANCH shows pc_write_cond = 1, alu_op = 01, pc_source = 01;
  - JUMP shows pc_write = 1, pc_source = 10;
  - each takes 3 cycles.
- op = 001000 (unsupported): illegal_op pulses for 1 cycle in DECODE, next state is 0, no write strobes.
- WAIT_LIMIT = 4, sw with mem_ready held 0:
  - wait_cnt reaches 4 in MEMWR, mem_timeout rises and stays 1;
  - next state is FETCH, mem_write is 0 in the abort cycle;
  - mem_ready arriving exactly on the limit cycle completes normally instead.
- reset asserted during MEMWR with mem_ready = 1:
  - all outputs are 0 that cycle and mem_timeout is cleared;
  - the state after the reset edge is 0.
